// File: rtl/adc_fifo_drain_seq_if.sv
// Register/strobe bus between adc_fifo_drain_seq (master) and the LTC2308 FIFO controller (slave).
interface adc_fifo_drain_seq_if;
    logic        addr;
    logic        write;
    logic [31:0] writedatain;
    logic        read_outdata;
    logic [31:0] readdataout;

    modport master (
        output addr,
        output write,
        output writedatain,
        output read_outdata,
        input  readdataout
    );

    modport slave (
        input  addr,
        input  write,
        input  writedatain,
        input  read_outdata,
        output readdataout
    );
endinterface

// File: rtl/adc_fifo_drain_seq.sv
// Sequencer that programs the LTC2308 FIFO controller, polls for burst done and drains its FIFO.
// Define ADC_DRAIN_AVG_EN to average 2^AVG_LOG2 samples per channel before updating ch_value.
module adc_fifo_drain_seq #(
    parameter int unsigned RD_HIGH      = 2,
    parameter int unsigned RD_GAP       = 4,
    parameter int unsigned POLL_TIMEOUT = 65535,
    parameter int unsigned AVG_LOG2     = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 i_run,
    input  logic [2:0]           i_cfg_ch,
    input  logic                 i_cfg_auto,
    input  logic [11:0]          i_cfg_num,
    adc_fifo_drain_seq_if.master ctl_if,
    output logic                 o_smp_valid,
    output logic [2:0]           o_smp_ch,
    output logic [11:0]          o_smp_data,
    output logic [95:0]          o_ch_value,
    output logic [7:0]           o_ch_fresh,
    output logic                 o_burst_done,
    output logic                 o_timeout_err
);
    localparam int unsigned CntW  = $clog2(RD_HIGH + RD_GAP + 1);
    localparam int unsigned PollW = $clog2(POLL_TIMEOUT + 1);
    localparam logic [CntW-1:0]  WrStrobe = CntW'(1);
    localparam logic [CntW-1:0]  WrLast   = CntW'(2);
    localparam logic [CntW-1:0]  RdLast   = CntW'(RD_HIGH);
    localparam logic [CntW-1:0]  RdEnd    = CntW'(RD_HIGH + RD_GAP);
    localparam logic [PollW-1:0] PollLast = PollW'(POLL_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle, StWrNum, StWrStop, StWrStart, StPoll, StDrain, StDone
    } state_e;

    state_e           r_state, w_state_d;
    logic [CntW-1:0]  r_cnt, w_cnt_d;
    logic [PollW-1:0] r_poll_cnt, w_poll_cnt_d;
    logic [11:0]      r_left, w_left_d;
    logic [2:0]       r_ch;
    logic             r_auto;
    logic [11:0]      r_num;
    logic             r_done;
    logic             r_run;
    logic             r_timeout_err;
    logic             r_smp_valid;
    logic [2:0]       r_smp_ch;
    logic [11:0]      r_smp_data;
    logic [11:0]      r_ch_val [8];
    logic [7:0]       r_ch_fresh;

    logic             w_latch, w_timeout, w_sample, w_done_now;
    logic             w_addr, w_write, w_read, w_burst_done;
    logic [31:0]      w_wdata;
    logic [2:0]       w_rd_ch;
    logic [11:0]      w_rd_data;
    logic             w_unused_rdata;

    assign w_rd_ch        = ctl_if.readdataout[18:16];
    assign w_rd_data      = ctl_if.readdataout[11:0];
    assign w_unused_rdata = ^{ctl_if.readdataout[31:19], ctl_if.readdataout[15:12]};
    assign w_sample       = ((r_state == StPoll) || (r_state == StDrain)) && (r_cnt == RdLast);
    // Lets a zero-length gap still decide on the word being sampled this cycle.
    assign w_done_now     = w_sample ? ctl_if.readdataout[0] : r_done;

`ifdef ADC_DRAIN_AVG_EN
    localparam int unsigned AccW  = 12 + AVG_LOG2;
    localparam int unsigned AcntW = AVG_LOG2 + 1;
    localparam logic [AcntW-1:0] AcntLast = AcntW'((1 << AVG_LOG2) - 1);

    logic [AccW-1:0]  r_acc  [8];
    logic [AcntW-1:0] r_acnt [8];
    logic [AccW-1:0]  w_acc_sum;

    assign w_acc_sum = r_acc[w_rd_ch] + AccW'(w_rd_data);
`else
    logic w_unused_avg;
    assign w_unused_avg = ^AVG_LOG2;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_poll_cnt <= '0;
            r_left     <= '0;
        end else begin
            r_state    <= w_state_d;
            r_cnt      <= w_cnt_d;
            r_poll_cnt <= w_poll_cnt_d;
            r_left     <= w_left_d;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_cnt_d      = r_cnt;
        w_poll_cnt_d = r_poll_cnt;
        w_left_d     = r_left;
        w_latch      = 1'b0;
        w_timeout    = 1'b0;
        w_addr       = 1'b0;
        w_write      = 1'b0;
        w_wdata      = '0;
        w_read       = 1'b0;
        w_burst_done = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_run) begin
                    w_latch   = 1'b1;
                    w_state_d = StWrNum;
                end
            end
            StWrNum, StWrStop, StWrStart: begin
                w_addr  = (r_state == StWrNum);
                w_write = (r_cnt == WrStrobe);
                if (r_state == StWrNum) begin
                    w_wdata = {20'b0, r_num};
                end else if (r_state == StWrStart) begin
                    w_wdata = {23'b0, r_auto, 1'b0, r_ch, 3'b0, 1'b1};
                end
                w_cnt_d = r_cnt + 1'b1;
                if (r_cnt == WrLast) begin
                    w_cnt_d   = '0;
                    w_state_d = (r_state == StWrNum)  ? StWrStop :
                                (r_state == StWrStop) ? StWrStart : StPoll;
                end
            end
            StPoll, StDrain: begin
                w_addr  = (r_state == StDrain);
                w_read  = (r_cnt != '0) && (r_cnt <= RdLast);
                w_cnt_d = r_cnt + 1'b1;
                if (r_cnt == RdEnd) begin
                    w_cnt_d = '0;
                    if (r_state == StDrain) begin
                        if (r_left <= 12'd1) begin
                            w_state_d = StDone;
                        end else begin
                            w_left_d = r_left - 12'd1;
                        end
                    end else if (w_done_now) begin
                        w_state_d = (r_num == '0) ? StDone : StDrain;
                    end else if (r_poll_cnt == PollLast) begin
                        w_timeout = 1'b1;
                        w_state_d = StIdle;
                    end else begin
                        w_poll_cnt_d = r_poll_cnt + 1'b1;
                    end
                end
            end
            StDone: begin
                w_burst_done = 1'b1;
                if (i_run) begin
                    w_latch   = 1'b1;
                    w_state_d = StWrNum;
                end else begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
        if (w_latch) begin
            w_cnt_d      = '0;
            w_poll_cnt_d = '0;
            w_left_d     = i_cfg_num;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ch          <= '0;
            r_auto        <= 1'b0;
            r_num         <= '0;
            r_done        <= 1'b0;
            r_run         <= 1'b0;
            r_timeout_err <= 1'b0;
            r_smp_valid   <= 1'b0;
            r_smp_ch      <= '0;
            r_smp_data    <= '0;
            r_ch_fresh    <= '0;
            for (int i = 0; i < 8; i++) begin
                r_ch_val[i] <= '0;
`ifdef ADC_DRAIN_AVG_EN
                r_acc[i]    <= '0;
                r_acnt[i]   <= '0;
`endif
            end
        end else begin
            r_run       <= i_run;
            r_smp_valid <= 1'b0;
            if (w_latch) begin
                r_ch       <= i_cfg_ch;
                r_auto     <= i_cfg_auto;
                r_num      <= i_cfg_num;
                r_ch_fresh <= '0;
`ifdef ADC_DRAIN_AVG_EN
                for (int i = 0; i < 8; i++) begin
                    r_acc[i]  <= '0;
                    r_acnt[i] <= '0;
                end
`endif
            end
            if (w_sample && (r_state == StPoll)) begin
                r_done <= ctl_if.readdataout[0];
            end
            if (w_sample && (r_state == StDrain)) begin
                r_smp_valid <= 1'b1;
                r_smp_ch    <= w_rd_ch;
                r_smp_data  <= w_rd_data;
`ifdef ADC_DRAIN_AVG_EN
                if (r_acnt[w_rd_ch] == AcntLast) begin
                    r_ch_val[w_rd_ch]   <= 12'(w_acc_sum >> AVG_LOG2);
                    r_ch_fresh[w_rd_ch] <= 1'b1;
                    r_acc[w_rd_ch]      <= '0;
                    r_acnt[w_rd_ch]     <= '0;
                end else begin
                    r_acc[w_rd_ch]  <= w_acc_sum;
                    r_acnt[w_rd_ch] <= r_acnt[w_rd_ch] + 1'b1;
                end
`else
                r_ch_val[w_rd_ch]   <= w_rd_data;
                r_ch_fresh[w_rd_ch] <= 1'b1;
`endif
            end
            // A new run request clears the sticky error; a same-cycle timeout still wins.
            if (i_run && !r_run) r_timeout_err <= 1'b0;
            if (w_timeout)       r_timeout_err <= 1'b1;
        end
    end

    for (genvar g = 0; g < 8; g++) begin : g_ch_value
        assign o_ch_value[12*g +: 12] = r_ch_val[g];
    end

    assign ctl_if.addr         = w_addr;
    assign ctl_if.write        = w_write;
    assign ctl_if.writedatain  = w_wdata;
    assign ctl_if.read_outdata = w_read;
    assign o_smp_valid         = r_smp_valid;
    assign o_smp_ch            = r_smp_ch;
    assign o_smp_data          = r_smp_data;
    assign o_ch_fresh          = r_ch_fresh;
    assign o_burst_done        = w_burst_done;
    assign o_timeout_err       = r_timeout_err;
endmodule

// File: tb/tb_adc_fifo_drain_seq.sv
// Bench for adc_fifo_drain_seq: FIFO-controller model on the bus plus a per-channel result model.
`timescale 1ns/1ps
module tb_adc_fifo_drain_seq;
    localparam int unsigned RdHigh  = 2;
    localparam int unsigned RdGap   = 4;
    localparam int unsigned PollTo  = 4;
    localparam int unsigned AvgLog2 = 2;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        run = 1'b0;
    logic [2:0]  cfg_ch = '0;
    logic        cfg_auto = 1'b0;
    logic [11:0] cfg_num = '0;
    logic        smp_valid, burst_done, timeout_err;
    logic [2:0]  smp_ch;
    logic [11:0] smp_data;
    logic [95:0] ch_value;
    logic [7:0]  ch_fresh;

    adc_fifo_drain_seq_if bus ();

    adc_fifo_drain_seq #(
        .RD_HIGH(RdHigh), .RD_GAP(RdGap), .POLL_TIMEOUT(PollTo), .AVG_LOG2(AvgLog2)
    ) dut (
        .clock(clock), .reset_n(reset_n), .i_run(run), .i_cfg_ch(cfg_ch), .i_cfg_auto(cfg_auto),
        .i_cfg_num(cfg_num), .ctl_if(bus), .o_smp_valid(smp_valid), .o_smp_ch(smp_ch),
        .o_smp_data(smp_data), .o_ch_value(ch_value), .o_ch_fresh(ch_fresh),
        .o_burst_done(burst_done), .o_timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // FIFO controller model
    logic [31:0] load_q[$];
    logic [31:0] fifo_q[$];
    logic [31:0] fifo_head = '0;
    logic        ctl_done = 1'b0;
    int          polls_seen = 0;
    int          done_after = 3;
    assign bus.readdataout = bus.addr ? fifo_head : {31'b0, ctl_done};

    // Bus observations and result model
    logic        wr_a_q[$];
    logic [31:0] wr_d_q[$];
    int          n_poll_rd = 0, n_data_rd = 0, n_done = 0, n_smp = 0;
    int          last_num = 0, burst_rd = 0;
    logic [14:0] m_exp_q[$];
    logic [11:0] m_val [8];
    logic [7:0]  m_fresh = '0;
    int          m_sum [8];
    int          m_cnt [8];
    logic        p_write = 1'b0, p_read = 1'b0, p_addr = 1'b0;
    logic        wr_a_rise = 1'b0, rd_a_rise = 1'b0;
    logic [31:0] wr_d_rise = '0;
    int          wr_len = 0, rd_len = 0;

    function automatic logic [31:0] word(input int ch, input int data);
        return (32'(ch) << 16) | 32'(data);
    endfunction

    function automatic logic [95:0] model_pack();
        logic [95:0] v;
        for (int i = 0; i < 8; i++) v[12*i +: 12] = m_val[i];
        return v;
    endfunction

    task automatic refresh_head();
        fifo_head = (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            m_val[i] = '0;
            m_sum[i] = 0;
            m_cnt[i] = 0;
        end
    end

    always @(negedge clock) begin
        if (!reset_n) begin
            p_write = 1'b0;
            p_read  = 1'b0;
            p_addr  = 1'b0;
            m_exp_q.delete();
            m_fresh = '0;
            for (int i = 0; i < 8; i++) begin
                m_val[i] = '0;
                m_sum[i] = 0;
                m_cnt[i] = 0;
            end
        end else begin
            if (bus.write) begin
                if (!p_write) begin
                    wr_a_rise = bus.addr;
                    wr_d_rise = bus.writedatain;
                    wr_a_q.push_back(bus.addr);
                    wr_d_q.push_back(bus.writedatain);
                    wr_len = 0;
                    if (bus.addr) begin
                        last_num = int'(bus.writedatain[11:0]);
                        burst_rd = 0;
                        m_fresh  = '0;
                        for (int i = 0; i < 8; i++) begin
                            m_sum[i] = 0;
                            m_cnt[i] = 0;
                        end
                    end else if (bus.writedatain[0]) begin
                        fifo_q = load_q;
                        polls_seen = 0;
                        ctl_done = 1'b0;
                        refresh_head();
                    end
                end
                wr_len++;
            end else if (p_write) begin
                check("write_high_len", 128'(wr_len), 128'd1);
                check("write_addr_data_held", {bus.addr, bus.writedatain}, {wr_a_rise, wr_d_rise});
            end

            if (bus.read_outdata) begin
                if (!p_read) begin
                    check("read_addr_setup", bus.addr, p_addr);
                    rd_a_rise = bus.addr;
                    rd_len = 0;
                    if (bus.addr) begin
                        n_data_rd++;
                        burst_rd++;
                        m_exp_q.push_back({fifo_head[18:16], fifo_head[11:0]});
                    end else begin
                        n_poll_rd++;
                        polls_seen++;
                        ctl_done = (polls_seen > done_after);
                    end
                end
                rd_len++;
            end else if (p_read) begin
                check("read_high_len", 128'(rd_len), 128'(RdHigh));
                check("read_addr_held", bus.addr, rd_a_rise);
                if (rd_a_rise && fifo_q.size() > 0) begin
                    void'(fifo_q.pop_front());
                    refresh_head();
                end
            end

            if (smp_valid) begin
                n_smp++;
                if (m_exp_q.size() == 0) begin
                    check("smp_unexpected", smp_valid, 1'b0);
                end else begin
                    logic [14:0] e;
                    e = m_exp_q.pop_front();
                    check("smp_ch", smp_ch, e[14:12]);
                    check("smp_data", smp_data, e[11:0]);
`ifdef ADC_DRAIN_AVG_EN
                    m_sum[e[14:12]] += int'(e[11:0]);
                    m_cnt[e[14:12]]++;
                    if (m_cnt[e[14:12]] == (1 << AvgLog2)) begin
                        m_val[e[14:12]]   = 12'(m_sum[e[14:12]] / (1 << AvgLog2));
                        m_fresh[e[14:12]] = 1'b1;
                        m_sum[e[14:12]]   = 0;
                        m_cnt[e[14:12]]   = 0;
                    end
`else
                    m_val[e[14:12]]   = e[11:0];
                    m_fresh[e[14:12]] = 1'b1;
`endif
                end
            end

            if (burst_done) begin
                n_done++;
                check("bd_pending_samples", 128'(m_exp_q.size()), 128'd0);
                check("bd_drain_reads", 128'(burst_rd), 128'(last_num));
                check("bd_ch_value", ch_value, model_pack());
                check("bd_ch_fresh", ch_fresh, m_fresh);
            end

            p_write = bus.write;
            p_read  = bus.read_outdata;
            p_addr  = bus.addr;
        end
    end

    task automatic wait_writes(input string name, input int n);
        int c = 0;
        while (wr_a_q.size() < n && c < 300) begin
            @(negedge clock);
            c++;
        end
        check(name, wr_a_q.size() >= n, 1'b1);
    endtask

    task automatic wait_done(input string name, input int n0);
        int c = 0;
        while (n_done == n0 && c < 600) begin
            @(negedge clock);
            c++;
        end
        check(name, n_done != n0, 1'b1);
    endtask

    task automatic setup(input logic [2:0] ch, input logic auto_en, input logic [11:0] num,
                         input int da);
        @(negedge clock);
        cfg_ch = ch;
        cfg_auto = auto_en;
        cfg_num = num;
        done_after = da;
        wr_a_q.delete();
        wr_d_q.delete();
    endtask

    // Issues one burst with run dropped right after the first write.
    task automatic one_burst(input string name);
        int n0;
        n0 = n_done;
        run = 1'b1;
        wait_writes({name, "_start"}, 1);
        run = 1'b0;
        wait_done({name, "_done"}, n0);
    endtask

    initial begin
        int p0, d0, s0, b0, c;

        repeat (3) @(posedge clock);
        #1;
        check("rst_strobes", {bus.addr, bus.write, bus.read_outdata}, 3'b000);
        check("rst_wdata", bus.writedatain, 32'h0);
        check("rst_flags", {smp_valid, burst_done, timeout_err}, 3'b000);
        check("rst_smp", {smp_ch, smp_data}, 15'h0);
        check("rst_ch_value", ch_value, 96'h0);
        check("rst_ch_fresh", ch_fresh, 8'h00);
        @(negedge clock);
        reset_n = 1'b1;

        // A: auto channel, 8 words, done on the 4th poll
        load_q.delete();
        for (int i = 0; i < 8; i++) load_q.push_back(word(i, 'h100 + i));
        setup(3'd0, 1'b1, 12'd8, 3);
        p0 = n_poll_rd; d0 = n_data_rd; s0 = n_smp; b0 = n_done;
        one_burst("A");
        check("A_nwrites", 128'(wr_a_q.size()), 128'd3);
        check("A_wr_num", {wr_a_q[0], wr_d_q[0]}, {1'b1, 32'h8});
        check("A_wr_stop", {wr_a_q[1], wr_d_q[1]}, {1'b0, 32'h0});
        check("A_wr_start", {wr_a_q[2], wr_d_q[2]}, {1'b0, 32'h101});
        check("A_polls", 128'(n_poll_rd - p0), 128'd4);
        check("A_data_reads", 128'(n_data_rd - d0), 128'd8);
        check("A_samples", 128'(n_smp - s0), 128'd8);
        check("A_ch_value", ch_value, {12'h107, 12'h106, 12'h105, 12'h104,
                                       12'h103, 12'h102, 12'h101, 12'h100});
        check("A_ch_fresh", ch_fresh, 8'hFF);
        repeat (30) @(negedge clock);
        check("A_idle_writes", 128'(wr_a_q.size()), 128'd3);
        check("A_one_done", 128'(n_done - b0), 128'd1);

        // B: zero-length burst, words present but never drained
        load_q = '{word(2, 'h7AA), word(2, 'h7BB)};
        setup(3'd2, 1'b0, 12'd0, 3);
        d0 = n_data_rd;
        one_burst("B");
        check("B_wr_num", wr_d_q[0], 32'h0);
        check("B_wr_start", wr_d_q[2], 32'h21);
        check("B_no_drain", 128'(n_data_rd - d0), 128'd0);
        check("B_ch_fresh", ch_fresh, 8'h00);
        check("B_ch_value_kept", ch_value[95:84], 12'h107);

        // C: done never arrives
        setup(3'd1, 1'b1, 12'd5, 1000);
        p0 = n_poll_rd; d0 = n_data_rd; b0 = n_done;
        run = 1'b1;
        wait_writes("C_start", 1);
        run = 1'b0;
        c = 0;
        while (!timeout_err && c < 300) begin
            @(negedge clock);
            c++;
        end
        check("C_timeout_set", timeout_err, 1'b1);
        repeat (20) @(negedge clock);
        check("C_polls", 128'(n_poll_rd - p0), 128'd4);
        check("C_no_drain", 128'(n_data_rd - d0), 128'd0);
        check("C_no_done", 128'(n_done - b0), 128'd0);
        check("C_idle_bus", {wr_a_q.size() == 3, bus.read_outdata, bus.write}, 3'b100);
        check("C_timeout_sticky", timeout_err, 1'b1);
        setup(3'd1, 1'b1, 12'd0, 0);
        p0 = n_poll_rd;
        run = 1'b1;
        @(posedge clock);
        #1;
        check("C_timeout_clr", timeout_err, 1'b0);
        wait_writes("C2_start", 1);
        run = 1'b0;
        wait_done("C2_done", b0);
        check("C2_polls", 128'(n_poll_rd - p0), 128'd1);

        // D: repeated channel plus one surplus word
        load_q = '{word(5, 'hAAA), word(5, 'h123), word(5, 'hFFF), word(5, 'h555)};
        setup(3'd5, 1'b0, 12'd3, 2);
        d0 = n_data_rd;
        one_burst("D");
        check("D_data_reads", 128'(n_data_rd - d0), 128'd3);
`ifndef ADC_DRAIN_AVG_EN
        check("D_last_wins", ch_value[71:60], 12'hFFF);
        check("D_ch_fresh", ch_fresh, 8'h20);
`endif

        // E: continuous run, config changed mid-burst, run dropped during drain
        load_q = '{word(0, 'h011), word(1, 'h022)};
        setup(3'd0, 1'b1, 12'd2, 1);
        b0 = n_done; d0 = n_data_rd;
        run = 1'b1;
        wait_writes("E_start", 3);
        cfg_num = 12'd3;
        load_q = '{word(2, 'h033), word(3, 'h044), word(4, 'h055)};
        wait_done("E1_done", b0);
        check("E1_data_reads", 128'(n_data_rd - d0), 128'd2);
        c = 0;
        while (n_data_rd < d0 + 3 && c < 300) begin
            @(negedge clock);
            c++;
        end
        check("E2_in_drain", n_data_rd >= d0 + 3, 1'b1);
        run = 1'b0;
        wait_done("E2_done", b0 + 1);
        repeat (30) @(negedge clock);
        check("E_nwrites", 128'(wr_a_q.size()), 128'd6);
        check("E_relatched_num", {wr_a_q[3], wr_d_q[3]}, {1'b1, 32'h3});
        check("E_data_reads", 128'(n_data_rd - d0), 128'd5);
        check("E_two_bursts", 128'(n_done - b0), 128'd2);

        // F: asynchronous reset in the middle of a drain read
        load_q = '{word(6, 'h111), word(6, 'h222), word(6, 'h333), word(6, 'h444)};
        setup(3'd6, 1'b0, 12'd4, 0);
        run = 1'b1;
        c = 0;
        while (!(bus.read_outdata && bus.addr) && c < 300) begin
            @(negedge clock);
            c++;
        end
        check("F_in_drain_read", bus.read_outdata && bus.addr, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("F_rd_drop", bus.read_outdata, 1'b0);
        check("F_bus_zero", {bus.addr, bus.write, bus.writedatain}, 34'h0);
        check("F_out_zero", {smp_valid, smp_ch, smp_data, burst_done, timeout_err}, 18'h0);
        check("F_bank_zero", {ch_value, ch_fresh}, 104'h0);
        run = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        wr_a_q.delete();
        wr_d_q.delete();
        repeat (10) @(negedge clock);
        check("F_idle_after", {wr_a_q.size() == 0, bus.read_outdata}, 2'b10);

`ifdef ADC_DRAIN_AVG_EN
        // G: fixed channel 3, four samples averaged
        load_q = '{word(3, 10), word(3, 11), word(3, 12), word(3, 13)};
        setup(3'd3, 1'b0, 12'd4, 3);
        s0 = n_smp;
        one_burst("G");
        check("G_samples", 128'(n_smp - s0), 128'd4);
        check("G_avg", ch_value[47:36], 12'd11);
        check("G_ch_fresh", ch_fresh, 8'h08);
`else
        // G: full restart after reset, single word
        load_q = '{word(7, 'hABC)};
        setup(3'd7, 1'b1, 12'd1, 0);
        one_burst("G");
        check("G_wr_start", wr_d_q[2], 32'h171);
        check("G_ch7", ch_value, {12'hABC, 84'h0});
        check("G_ch_fresh", ch_fresh, 8'h80);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
